// File: rtl/alarm_pkg.sv
// alarm_pkg: shared cursor type, seven-segment codes and time-of-day arithmetic.
package alarm_pkg;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 4;
    typedef enum logic [1:0] {CUR_MIN, CUR_HOUR, CUR_DAY, CUR_AMPM} cursor_e;
    typedef struct packed {
        logic              pm;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
    } tod_t;
    localparam tod_t TOD_RESET = '{pm: 1'b0, hour: 4'd12, min: 6'd0};
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
        return m == 6'd59 ? 6'd0 : m + 6'd1;
    endfunction
    function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
        return h == 4'd12 ? 4'd1 : h + 4'd1;
    endfunction
    function automatic tod_t tick_tod(input tod_t t);
        tod_t r;
        logic wrap;
        wrap   = t.min == 6'd59;
        r.min  = inc_min(t.min);
        r.hour = wrap ? inc_hour(t.hour) : t.hour;
        r.pm   = t.pm ^ (wrap && t.hour == 4'd11);
        return r;
    endfunction
    function automatic tod_t add_min(input tod_t t, input int n);
        tod_t r;
        r = t;
        for (int i = 0; i < n; i++) r = tick_tod(r);
        return r;
    endfunction
    function automatic tod_t edit_tod(input tod_t t, input cursor_e c);
        tod_t r;
        r.min  = c == CUR_MIN ? inc_min(t.min) : t.min;
        r.hour = c == CUR_HOUR ? inc_hour(t.hour) : t.hour;
        r.pm   = t.pm ^ (c == CUR_AMPM);
        return r;
    endfunction
    function automatic logic [6:0] rot_days(input logic [6:0] d);
        return {d[5:0], d[6]};
    endfunction
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD digit to gfedcba segments, with a blank override.
module seg7_decoder
    import alarm_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank)
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
    end
endmodule

// File: rtl/alarm_clock_datapath.sv
// alarm_clock_datapath: 12-hour clock/alarm registers, edit cursor, muxed display and buzzer.
module alarm_clock_datapath
    import alarm_pkg::*;
#(
    parameter int CLK_PER_MIN = 8,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Next,
    input  logic       Up,
    input  logic       SetTime,
    input  logic       SetAlarm,
    input  logic       Snooze,
    input  logic       Stop,
    input  logic       Mute,
    output logic [6:0] display_out,
    output logic [6:0] days,
    output logic [3:0] segment_digit,
    output logic       am,
    output logic       pm,
    output logic       dblink,
    output logic       Sound
);
    localparam int CW = $clog2(CLK_PER_MIN + 1);
    localparam logic [CW-1:0] TC = CW'(CLK_PER_MIN - 1);
    localparam logic [CW-1:0] HC = CW'(CLK_PER_MIN / 2 - 1);

    logic [3:0] btn_q;
    logic next_e, up_e, snooze_e, stop_e;
    logic up_time, up_alarm, tick_evt, midnight, snz, ring;
    cursor_e cursor;
    tod_t tod, alarm, snz_tod, shown, tod_tick, eff;
    logic [CW-1:0] cnt;
    logic [3:0] dig_next, digit_val;
    logic digit_blank;
    logic [6:0] seg_next;

    assign {next_e, up_e, snooze_e, stop_e} = {Next, Up, Snooze, Stop} & ~btn_q;
    assign up_time  = up_e && !SetAlarm;
    assign up_alarm = up_e && SetAlarm;
    assign tick_evt = !SetTime && cnt == TC && !up_time;
    assign midnight = tod.pm && tod.hour == 4'd11 && tod.min == 6'd59;
    assign tod_tick = tick_tod(tod);
    assign eff      = snz ? snz_tod : alarm;
    assign shown    = SetAlarm ? alarm : tod;
    assign am       = ~shown.pm;
    assign pm       = shown.pm;
    assign Sound    = ring && !Mute;

    assign dig_next    = {segment_digit[2:0], segment_digit[3]};
    assign digit_val   = dig_next[0] ? 4'(shown.min % 6'd10) :
                         dig_next[1] ? 4'(shown.min / 6'd10) :
                         dig_next[2] ? (shown.hour >= 4'd10 ? shown.hour - 4'd10 : shown.hour) :
                         {3'b0, shown.hour >= 4'd10};
    assign digit_blank = dig_next[3] && shown.hour < 4'd10;

    seg7_decoder u_seg (.bcd(digit_val), .blank(digit_blank), .seg(seg_next));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            btn_q         <= '0;
            cursor        <= CUR_MIN;
            cnt           <= '0;
            tod           <= TOD_RESET;
            alarm         <= TOD_RESET;
            snz_tod       <= TOD_RESET;
            snz           <= 1'b0;
            ring          <= 1'b0;
            days          <= 7'b0000001;
            dblink        <= 1'b0;
            segment_digit <= 4'b0001;
            display_out   <= SEG_0;
        end else begin
            btn_q         <= {Next, Up, Snooze, Stop};
            cursor        <= next_e ? cursor_e'(cursor + 2'd1) : cursor;
            cnt           <= SetTime ? cnt : cnt == TC ? '0 : cnt + CW'(1);
            tod           <= up_time ? edit_tod(tod, cursor) : tick_evt ? tod_tick : tod;
            alarm         <= up_alarm ? edit_tod(alarm, cursor) : alarm;
            days          <= (up_time && cursor == CUR_DAY) || (tick_evt && midnight) ? rot_days(days) : days;
            dblink        <= SetTime || SetAlarm ? 1'b1 : (cnt == HC || cnt == TC) ? ~dblink : dblink;
            snz           <= !(stop_e || up_alarm) && (snooze_e || snz);
            snz_tod       <= snooze_e ? add_min(tod, SNOOZE_MIN) : snz_tod;
            ring          <= !(stop_e || snooze_e) && (ring || (tick_evt && !Mute && tod_tick == eff));
            segment_digit <= dig_next;
            display_out   <= seg_next;
        end
    end
endmodule

// File: tb/tb_alarm_clock_datapath.sv
// tb_alarm_clock_datapath: directed table and sequence checks of the alarm clock datapath.
module tb_alarm_clock_datapath;
    localparam int B_NEXT = 0, B_UP = 1, B_SNZ = 2, B_STOP = 3, B_BOTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic nxt = 0, up = 0, set_time = 1, set_alarm = 0, snz = 0, stp = 0, mute = 0;
    logic [6:0] display_out, days;
    logic [3:0] segment_digit;
    logic am, pm, dblink, sound;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    alarm_clock_datapath #(.CLK_PER_MIN(8), .SNOOZE_MIN(5)) dut (
        .Clk(clk), .Reset(rst_n), .Next(nxt), .Up(up), .SetTime(set_time), .SetAlarm(set_alarm),
        .Snooze(snz), .Stop(stp), .Mute(mute), .display_out(display_out), .days(days),
        .segment_digit(segment_digit), .am(am), .pm(pm), .dblink(dblink), .Sound(sound)
    );

    typedef struct {
        int         nexts;
        int         up_len;
        bit         alarm;
        int         h;
        int         m;
        bit         is_pm;
        logic [6:0] dy;
    } vec_t;
    vec_t vecs [10];

    function automatic logic [6:0] sg(input int v);
        case (v)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [27:0] exp_disp(input int h, input int m);
        return {h >= 10 ? sg(1) : 7'b0, sg(h % 10), sg(m / 10), sg(m % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_NEXT:  nxt = v;
            B_UP:    up = v;
            B_SNZ:   snz = v;
            B_STOP:  stp = v;
            default: begin stp = v; snz = v; end
        endcase
    endtask

    task automatic press(input int b, input int len);
        set_btn(b, 1'b1);
        repeat (len) @(negedge clk);
        set_btn(b, 1'b0);
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap(output logic [27:0] d);
        logic [6:0] s [4];
        for (int i = 0; i < 4; i++) s[i] = 7'h7f;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            case (segment_digit)
                4'b0001: s[0] = display_out;
                4'b0010: s[1] = display_out;
                4'b0100: s[2] = display_out;
                4'b1000: s[3] = display_out;
                default: ;
            endcase
        end
        d = {s[3], s[2], s[1], s[0]};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_alarm_1201();
        set_time = 1'b1;
        do_reset();
        set_alarm = 1'b1;
        press(B_UP, 1);
        set_alarm = 1'b0;
    endtask

    initial begin
        logic [27:0] d;
        logic [7:0] pat;
        bit ok;
        vecs[0] = '{0, 6, 0, 12, 1, 0, 7'b0000001};
        vecs[1] = '{1, 1, 0, 1, 1, 0, 7'b0000001};
        vecs[2] = '{1, 1, 0, 1, 1, 0, 7'b0000010};
        vecs[3] = '{1, 1, 0, 1, 1, 1, 7'b0000010};
        vecs[4] = '{1, 1, 0, 1, 2, 1, 7'b0000010};
        vecs[5] = '{0, 1, 1, 12, 1, 0, 7'b0000010};
        vecs[6] = '{2, 1, 1, 12, 1, 0, 7'b0000010};
        vecs[7] = '{1, 1, 1, 12, 1, 1, 7'b0000010};
        vecs[8] = '{1, 1, 0, 1, 3, 1, 7'b0000010};
        vecs[9] = '{1, 1, 1, 1, 1, 1, 7'b0000010};

        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset days", days, 7'b0000001);
        check("reset am/pm", {am, pm}, 2'b10);
        check("reset sound", sound, 0);
        check("reset dblink", dblink, 0);
        check("reset digit0", {segment_digit, display_out}, {4'b0001, sg(0)});
        rst_n = 1'b1;
        @(negedge clk);
        check("digit1", {segment_digit, display_out}, {4'b0010, sg(0)});
        @(negedge clk);
        check("digit2", {segment_digit, display_out}, {4'b0100, sg(2)});
        @(negedge clk);
        check("digit3", {segment_digit, display_out}, {4'b1000, sg(1)});

        for (int i = 0; i < 10; i++) begin
            set_alarm = vecs[i].alarm;
            repeat (vecs[i].nexts) press(B_NEXT, 1);
            press(B_UP, vecs[i].up_len);
            snap(d);
            check($sformatf("vec%0d disp", i), d, exp_disp(vecs[i].h, vecs[i].m));
            check($sformatf("vec%0d am/pm", i), {am, pm}, vecs[i].is_pm ? 2'b01 : 2'b10);
            check($sformatf("vec%0d days", i), days, vecs[i].dy);
            check($sformatf("vec%0d dblink", i), dblink, 1);
        end
        set_alarm = 1'b0;

        set_time = 1'b1;
        do_reset();
        repeat (59) press(B_UP, 1);
        press(B_NEXT, 1);
        repeat (11) press(B_UP, 1);
        press(B_NEXT, 1);
        press(B_NEXT, 1);
        press(B_UP, 1);
        snap(d);
        check("set 11:59 disp", d, exp_disp(11, 59));
        check("set 11:59 pm", {am, pm}, 2'b01);
        set_time = 1'b0;
        tick(8);
        set_time = 1'b1;
        snap(d);
        check("midnight disp", d, exp_disp(12, 0));
        check("midnight am", {am, pm}, 2'b10);
        check("midnight days", days, 7'b0000010);

        set_time = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pat[k] = dblink;
        end
        check("dblink pattern", pat, 8'b0111_1000);
        tick(472);
        set_time = 1'b1;
        snap(d);
        check("one hour disp", d, exp_disp(1, 0));
        check("one hour am", {am, pm}, 2'b10);
        ok = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (dblink !== 1'b1) ok = 1'b0;
        end
        check("freeze dblink", ok, 1);
        snap(d);
        check("freeze disp", d, exp_disp(1, 0));

        set_alarm_1201();
        set_time = 1'b0;
        tick(8);
        check("alarm ring", sound, 1);
        mute = 1'b1;
        #1 check("mute masks", sound, 0);
        mute = 1'b0;
        #1 check("mute keeps ring", sound, 1);
        press(B_STOP, 1);
        check("stop silences", sound, 0);

        set_alarm_1201();
        mute = 1'b1;
        set_time = 1'b0;
        tick(8);
        check("muted no ring", sound, 0);
        mute = 1'b0;
        @(negedge clk);
        check("mute blocked trigger", sound, 0);

        set_alarm_1201();
        set_time = 1'b0;
        tick(8);
        check("snz ring", sound, 1);
        press(B_SNZ, 1);
        check("snooze silences", sound, 0);
        tick(37);
        check("before 12:06", sound, 0);
        tick(1);
        check("snooze re-ring", sound, 1);
        press(B_BOTH, 1);
        check("stop+snooze silences", sound, 0);
        tick(48);
        check("stop wins over snooze", sound, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alarm_clock_datapath.md
Name: alarm_clock_datapath

Overview:
- Datapath of a 12-hour alarm clock: runs the current time (minute, hour, AM/PM, day of week) and holds one alarm setting.
- Contains a small edit-cursor FSM, a multiplexed 4-digit seven-segment driver, a colon-blink output and the alarm-sound logic.
- Sits between the debounced push-buttons and the display/buzzer pins.

Parameters:
- CLK_PER_MIN, 8, clocks per running minute (set to 60*f_clk for silicon).
- SNOOZE_MIN, 5, minutes added to the alarm on Snooze.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Next  in  1  button: advance edit cursor.
- Up  in  1  button: increment the field under the cursor.
- SetTime  in  1  level: freeze running time while editing.
- SetAlarm  in  1  level: Up edits and display shows the alarm instead of the time.
- Snooze  in  1  button: silence and re-arm SNOOZE_MIN later.
- Stop  in  1  button: silence, no re-arm.
- Mute  in  1  level: forces Sound low and blocks triggering.
- display_out  out  7  segments gfedcba, active-high.
- days  out  7  one-hot day of week (bit0 = day 0).
- segment_digit  out  4  one-hot active-high digit enable.
- am  out  1  high when displayed hour is AM.
- pm  out  1  high when displayed hour is PM (= ~am).
- dblink  out  1  colon blink.
- Sound  out  1  alarm buzzer.

Behaviour:
- Reset (async, Reset=0):
  - time 12:00 AM, days=0000001; alarm 12:00 AM.
  - cursor state A, Sound=0, dblink=0, segment_digit=0001.
  - tick counter, snooze state and edge registers all cleared.
- Buttons: Next, Up, Snooze and Stop are rising-edge detected with one register each. A held button counts once and acts on the clock after the edge.
- Cursor FSM (states A..D):
  - A=MIN, B=HOUR, C=DAY, D=AMPM.
  - Each Next edge moves A->B->C->D->A.
- Up edge edits the field under the cursor. The target is the alarm register if SetAlarm=1, otherwise the time register.
  - MIN: 59 wraps to 0, no carry into the hour.
  - HOUR: order 12,1..11,12; no AM/PM change.
  - DAY: rotate days left, bit6 wraps to bit0. In the alarm target this is ignored, because the alarm is daily.
  - AMPM: toggle AM/PM.
- Running time:
  - Tick counter counts 0..CLK_PER_MIN-1 and is held while SetTime=1.
  - At terminal count the minute increments.
  - 59 -> 0 carries into the hour; 11 -> 12 toggles AM/PM.
  - 11:59 PM -> 12:00 AM also rotates days.
  - If an Up edit on the time register and a tick carry land in the same cycle, the edit wins and the tick is dropped.
- Display:
  - segment_digit rotates left one position every clock.
  - Digit mapping: 0001 = minute units, 0010 = minute tens, 0100 = hour units, 1000 = hour tens (blank when 0).
  - display_out is registered together with segment_digit, so the enable and its segments are aligned.
  - am/pm follow the displayed register (time or alarm).
  - Encoding: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, blank=0000000.
- dblink:
  - Toggles every CLK_PER_MIN/2 clocks while running.
  - Held at 1 while SetTime or SetAlarm is 1.
- Alarm:
  - Triggers on a minute-change event where the new time equals the effective alarm (hour, minute, AM/PM) and Mute=0.
  - Sound is then set and stays high until Stop, Snooze or Reset.
  - Mute=1 forces Sound output 0 but does not clear the ringing flag.
  - Snooze: clear Sound and set the effective alarm to the current time + SNOOZE_MIN (with wrap). The programmed alarm is unchanged.
  - Stop: clear Sound and restore the effective alarm to the programmed alarm.
  - Stop and Snooze in the same cycle: Stop wins.
  - Editing the alarm cancels any pending snooze.

Decomposition:
- Package alarm_pkg holds:
  - the cursor state enum (A..D);
  - the seven-segment constants and BLANK;
  - the time-record widths (min 6b, hour 4b, pm 1b).
- One natural sub-module: seg7_decoder, a combinational 4-bit BCD to 7-segment converter with a blank input.
- The increment/wrap helpers are package functions.

Test Plan:
- Reset -> days=0000001, am=1, pm=0, Sound=0; over 4 clocks display_out shows 0111111, 0111111, 1011011, 0000110 for digits 00 and 12.
- Up held 6 clocks at cursor A -> minute = 01 exactly once; Next then Up -> hour 12->1; Next then Up -> days=0000010; Next then Up -> pm=1.
- SetTime=0, run 60*CLK_PER_MIN clocks from 12:00 AM -> 1:00 AM. Starting from 11:59 PM, one minute later -> 12:00 AM and days rotates.
- Alarm at 12:01 AM, run one minute -> Sound=1. Stop -> 0. With Mute=1 the same setup gives Sound=0.
- Ringing at 12:01, Snooze -> Sound=0, then Sound=1 again at 12:06 AM.
- SetTime=1 for 3*CLK_PER_MIN clocks -> time is unchanged and dblink=1 constantly.
